wt_dcache_rd_arb: RTL and testbench

// Shares the single dcache memory read port among NumPorts wt_dcache_ctrl-style read controllers.

---
 rtl/wt_cache_pkg.sv | 25 ++
 rtl/wt_dcache_rr_pick.sv | 39 +++
 rtl/wt_dcache_rd_arb.sv | 129 ++++++++++++
 tb/tb_wt_dcache_rd_arb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// ============================================================================
// Module      : wt_cache_pkg
// Description : Shared dcache geometry constants and read-request record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wt_cache_pkg;

    localparam int unsigned DCACHE_CL_IDX_WIDTH = 8;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
    localparam int unsigned DCACHE_TAG_WIDTH    = 20;
    localparam int unsigned DCACHE_SET_ASSOC    = 4;
    localparam int unsigned DCACHE_NUM_RD_PORTS = 3;

    typedef struct packed {
        logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
        logic [DCACHE_OFFSET_WIDTH-1:0] off;
        logic                           approx;
        logic                           tag_only;
    } dcache_rd_req_t;

endpackage

`default_nettype wire

// File: rtl/wt_dcache_rr_pick.sv
// ============================================================================
// Module      : wt_dcache_rr_pick
// Description : Combinational round-robin find-first starting at a pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wt_dcache_rr_pick #(
    parameter int unsigned NumPorts = 3,
    parameter int unsigned SelW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic [NumPorts-1:0] req_i,
    input  logic [SelW-1:0]     ptr_i,
    output logic [SelW-1:0]     idx_o,
    output logic                vld_o
);

    // Walk from the farthest candidate back to the pointer so the closest one wins.
    always_comb begin
        int w_base;
        int w_cand;
        idx_o  = '0;
        vld_o  = 1'b0;
        w_base = (int'(ptr_i) >= int'(NumPorts)) ? 0 : int'(ptr_i);
        for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
            w_cand = w_base + i;
            if (w_cand >= int'(NumPorts)) begin
                w_cand = w_cand - int'(NumPorts);
            end
            if (req_i[w_cand]) begin
                idx_o = SelW'(w_cand);
                vld_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wt_dcache_rd_arb.sv
// ============================================================================
// Module      : wt_dcache_rd_arb
// Description : Round-robin arbiter sharing the dcache memory read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wt_dcache_rd_arb
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumPorts     = DCACHE_NUM_RD_PORTS,
    parameter int unsigned PerfCntWidth = 16
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NumPorts-1:0]                           rd_req_i,
    input  logic [NumPorts-1:0][DCACHE_CL_IDX_WIDTH-1:0]  rd_idx_i,
    input  logic [NumPorts-1:0][DCACHE_OFFSET_WIDTH-1:0]  rd_off_i,
    input  logic [NumPorts-1:0]                           rd_approx_i,
    input  logic [NumPorts-1:0]                           rd_tag_only_i,
    input  logic [NumPorts-1:0][DCACHE_TAG_WIDTH-1:0]     rd_tag_i,
    output logic [NumPorts-1:0]                           rd_ack_o,
    output logic [NumPorts-1:0]                           rd_rvld_o,
    output logic [63:0]                                   rd_data_o,
    output logic [DCACHE_SET_ASSOC-1:0]                   rd_vld_bits_o,
    output logic [DCACHE_SET_ASSOC-1:0]                   rd_hit_oh_o,
    output logic                                          mem_rd_req_o,
    input  logic                                          mem_rd_ack_i,
    output logic [DCACHE_CL_IDX_WIDTH-1:0]                mem_rd_idx_o,
    output logic [DCACHE_OFFSET_WIDTH-1:0]                mem_rd_off_o,
    output logic                                          mem_rd_approx_o,
    output logic                                          mem_rd_tag_only_o,
    output logic [DCACHE_TAG_WIDTH-1:0]                   mem_rd_tag_o,
    input  logic [63:0]                                   mem_rd_data_i,
    input  logic [DCACHE_SET_ASSOC-1:0]                   mem_rd_vld_bits_i,
    input  logic [DCACHE_SET_ASSOC-1:0]                   mem_rd_hit_oh_i,
    output logic [PerfCntWidth-1:0]                       lost_cnt_o
);

    localparam int unsigned c_SEL_W = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    dcache_rd_req_t          w_req [NumPorts];
    dcache_rd_req_t          w_win_req;
    logic [c_SEL_W-1:0]      w_win;
    logic                    w_any;
    logic                    w_grant;
    logic                    w_lost;

    logic [c_SEL_W-1:0]      r_rr_ptr;
    logic [c_SEL_W-1:0]      r_sel;
    logic                    r_vld;
    logic [PerfCntWidth-1:0] r_lost_cnt;

    for (genvar p = 0; p < NumPorts; p++) begin : g_req
        assign w_req[p] = '{idx:      rd_idx_i[p],
                            off:      rd_off_i[p],
                            approx:   rd_approx_i[p],
                            tag_only: rd_tag_only_i[p]};
    end

    wt_dcache_rr_pick #(
        .NumPorts (NumPorts),
        .SelW     (c_SEL_W)
    ) i_pick (
        .req_i (rd_req_i),
        .ptr_i (r_rr_ptr),
        .idx_o (w_win),
        .vld_o (w_any)
    );

    assign w_win_req         = w_req[w_win];
    assign mem_rd_req_o      = w_any;
    assign mem_rd_idx_o      = w_win_req.idx;
    assign mem_rd_off_o      = w_win_req.off;
    assign mem_rd_approx_o   = w_win_req.approx;
    assign mem_rd_tag_only_o = w_win_req.tag_only;
    assign w_grant           = w_any & mem_rd_ack_i;

    // Response stage: tag and return routing follow the port granted last cycle.
    assign mem_rd_tag_o  = rd_tag_i[r_sel];
    assign rd_data_o     = mem_rd_data_i;
    assign rd_vld_bits_o = mem_rd_vld_bits_i;
    assign rd_hit_oh_o   = mem_rd_hit_oh_i;
    assign lost_cnt_o    = r_lost_cnt;

    always_comb begin
        rd_ack_o  = '0;
        rd_rvld_o = '0;
        if (w_grant) begin
            rd_ack_o[w_win] = 1'b1;
        end
        if (r_vld) begin
            rd_rvld_o[r_sel] = 1'b1;
        end
    end

    // A cycle is lost when any requester is left waiting, including memory stalls.
    always_comb begin
        w_lost = w_grant ? ($countones(rd_req_i) > 1) : w_any;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_sel      <= '0;
            r_vld      <= 1'b0;
            r_lost_cnt <= '0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= (w_win == c_SEL_W'(NumPorts - 1)) ? '0 : w_win + 1'b1;
                r_sel    <= w_win;
            end
            r_vld <= w_grant;
            if (w_lost && (r_lost_cnt != '1)) begin
                r_lost_cnt <= r_lost_cnt + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_ack_onehot0  : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rd_ack_o));
    a_rvld_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rd_rvld_o));
    a_no_ack_stall : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                      !mem_rd_ack_i |-> (rd_ack_o == '0));
`endif

endmodule

`default_nettype wire

// File: tb/tb_wt_dcache_rd_arb.sv
// ============================================================================
// Module      : tb_wt_dcache_rd_arb
// Description : Self-checking bench for the dcache read-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wt_dcache_rd_arb;
    import wt_cache_pkg::*;

    localparam int N   = 3;
    localparam int PW  = 4;
    localparam int MAX = (1 << PW) - 1;

    logic                                  clk_i  = 1'b0;
    logic                                  rst_ni = 1'b0;
    logic [N-1:0]                          rd_req_i;
    logic [N-1:0][DCACHE_CL_IDX_WIDTH-1:0] rd_idx_i;
    logic [N-1:0][DCACHE_OFFSET_WIDTH-1:0] rd_off_i;
    logic [N-1:0]                          rd_approx_i;
    logic [N-1:0]                          rd_tag_only_i;
    logic [N-1:0][DCACHE_TAG_WIDTH-1:0]    rd_tag_i;
    logic [N-1:0]                          rd_ack_o;
    logic [N-1:0]                          rd_rvld_o;
    logic [63:0]                           rd_data_o;
    logic [DCACHE_SET_ASSOC-1:0]           rd_vld_bits_o;
    logic [DCACHE_SET_ASSOC-1:0]           rd_hit_oh_o;
    logic                                  mem_rd_req_o;
    logic                                  mem_rd_ack_i;
    logic [DCACHE_CL_IDX_WIDTH-1:0]        mem_rd_idx_o;
    logic [DCACHE_OFFSET_WIDTH-1:0]        mem_rd_off_o;
    logic                                  mem_rd_approx_o;
    logic                                  mem_rd_tag_only_o;
    logic [DCACHE_TAG_WIDTH-1:0]           mem_rd_tag_o;
    logic [63:0]                           mem_rd_data_i;
    logic [DCACHE_SET_ASSOC-1:0]           mem_rd_vld_bits_i;
    logic [DCACHE_SET_ASSOC-1:0]           mem_rd_hit_oh_i;
    logic [PW-1:0]                         lost_cnt_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    wt_dcache_rd_arb #(
        .NumPorts     (N),
        .PerfCntWidth (PW)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .rd_req_i          (rd_req_i),
        .rd_idx_i          (rd_idx_i),
        .rd_off_i          (rd_off_i),
        .rd_approx_i       (rd_approx_i),
        .rd_tag_only_i     (rd_tag_only_i),
        .rd_tag_i          (rd_tag_i),
        .rd_ack_o          (rd_ack_o),
        .rd_rvld_o         (rd_rvld_o),
        .rd_data_o         (rd_data_o),
        .rd_vld_bits_o     (rd_vld_bits_o),
        .rd_hit_oh_o       (rd_hit_oh_o),
        .mem_rd_req_o      (mem_rd_req_o),
        .mem_rd_ack_i      (mem_rd_ack_i),
        .mem_rd_idx_o      (mem_rd_idx_o),
        .mem_rd_off_o      (mem_rd_off_o),
        .mem_rd_approx_o   (mem_rd_approx_o),
        .mem_rd_tag_only_o (mem_rd_tag_only_o),
        .mem_rd_tag_o      (mem_rd_tag_o),
        .mem_rd_data_i     (mem_rd_data_i),
        .mem_rd_vld_bits_i (mem_rd_vld_bits_i),
        .mem_rd_hit_oh_i   (mem_rd_hit_oh_i),
        .lost_cnt_o        (lost_cnt_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: scan for the first requester from the pointer, then track
    // who was served last and how many cycles left someone waiting.
    initial begin
        int  m_ptr, m_sel, m_lost, w, pop, p;
        bit  m_vld, live;
        int  n_ptr, n_sel, n_lost;
        bit  n_vld;
        logic [N-1:0] e_ack;
        m_ptr = 0; m_sel = 0; m_vld = 0; m_lost = 0;
        forever begin
            @(negedge clk_i);
            live = rst_ni;
            if (!rst_ni) begin
                m_ptr = 0; m_sel = 0; m_vld = 0; m_lost = 0;
            end
            w = -1;
            for (int k = N - 1; k >= 0; k--) begin
                p = (m_ptr + k) % N;
                if (rd_req_i[p]) w = p;
            end
            e_ack = (w >= 0 && mem_rd_ack_i) ? N'(1 << w) : '0;
            check("ack",      rd_ack_o, e_ack);
            check("mem_req",  mem_rd_req_o, (w >= 0));
            check("rvld",     rd_rvld_o, m_vld ? N'(1 << m_sel) : '0);
            check("tag",      mem_rd_tag_o, rd_tag_i[m_sel]);
            check("data",     rd_data_o, mem_rd_data_i);
            check("vld_bits", rd_vld_bits_o, mem_rd_vld_bits_i);
            check("hit_oh",   rd_hit_oh_o, mem_rd_hit_oh_i);
            check("lost_cnt", lost_cnt_o, m_lost);
            if (w >= 0) begin
                check("mem_idx", {mem_rd_idx_o, mem_rd_off_o, mem_rd_approx_o, mem_rd_tag_only_o},
                      {rd_idx_i[w], rd_off_i[w], rd_approx_i[w], rd_tag_only_i[w]});
            end
            pop    = $countones(rd_req_i);
            n_ptr  = m_ptr; n_sel = m_sel; n_lost = m_lost;
            n_vld  = (e_ack != 0);
            if (e_ack != 0) begin
                n_ptr = (w + 1) % N;
                n_sel = w;
            end
            if (pop > ((e_ack != 0) ? 1 : 0) && n_lost < MAX) n_lost++;
            @(posedge clk_i);
            if (live && rst_ni) begin
                m_ptr = n_ptr; m_sel = n_sel; m_vld = n_vld; m_lost = n_lost;
            end
        end
    end

    task automatic step(input logic [N-1:0] req, input logic mack);
        @(posedge clk_i);
        #1;
        rd_req_i          = req;
        mem_rd_ack_i      = mack;
        mem_rd_data_i     = {$urandom, $urandom};
        mem_rd_vld_bits_i = DCACHE_SET_ASSOC'($urandom);
        mem_rd_hit_oh_i   = DCACHE_SET_ASSOC'(1 << $urandom_range(DCACHE_SET_ASSOC - 1, 0));
    endtask

    initial begin
        rd_req_i = '0; mem_rd_ack_i = 1'b0;
        mem_rd_data_i = '0; mem_rd_vld_bits_i = '0; mem_rd_hit_oh_i = '0;
        for (int i = 0; i < N; i++) begin
            rd_idx_i[i]      = DCACHE_CL_IDX_WIDTH'(i * 37 + 5);
            rd_off_i[i]      = DCACHE_OFFSET_WIDTH'(i * 3 + 1);
            rd_approx_i[i]   = i[0];
            rd_tag_only_i[i] = ~i[0];
            rd_tag_i[i]      = DCACHE_TAG_WIDTH'(20'hA0000 + i * 20'h01111);
        end
        repeat (3) step('0, 1'b0);
        @(negedge clk_i);
        check("rst_ack", rd_ack_o, 3'b000);
        check("rst_rvld", rd_rvld_o, 3'b000);
        check("rst_lost", lost_cnt_o, 0);
        @(posedge clk_i); #1 rst_ni = 1'b1;

        // All requesting: rotation 0,1,2,0
        step(3'b111, 1'b1); @(negedge clk_i); check("rr0", rd_ack_o, 3'b001);
        step(3'b111, 1'b1); @(negedge clk_i); check("rr1", rd_ack_o, 3'b010);
        check("rr1_rvld", rd_rvld_o, 3'b001);
        step(3'b111, 1'b1); @(negedge clk_i); check("rr2", rd_ack_o, 3'b100);
        step(3'b111, 1'b1); @(negedge clk_i); check("rr3", rd_ack_o, 3'b001);
        step(3'b000, 1'b1); @(negedge clk_i); check("rr_rvld", rd_rvld_o, 3'b001);
        check("lost4", lost_cnt_o, 4);

        // Single requester on port 1
        step(3'b010, 1'b1); @(negedge clk_i); check("single_ack", rd_ack_o, 3'b010);
        step(3'b000, 1'b1); @(negedge clk_i);
        check("single_rvld", rd_rvld_o, 3'b010);
        check("single_tag", mem_rd_tag_o, 20'hA1111);
        check("single_data", rd_data_o, mem_rd_data_i);

        // Pointer at 2 wraps to port 0
        step(3'b011, 1'b1); @(negedge clk_i); check("wrap0", rd_ack_o, 3'b001);
        step(3'b011, 1'b1); @(negedge clk_i); check("wrap1", rd_ack_o, 3'b010);
        step(3'b100, 1'b1); @(negedge clk_i); check("p2", rd_ack_o, 3'b100);
        check("lost6", lost_cnt_o, 6);

        // Memory stall
        repeat (4) begin
            step(3'b101, 1'b0); @(negedge clk_i); check("stall", rd_ack_o, 3'b000);
        end
        step(3'b101, 1'b1); @(negedge clk_i); check("stall_rel", rd_ack_o, 3'b001);
        check("lost10", lost_cnt_o, 10);
        step(3'b000, 1'b1); @(negedge clk_i); check("lost11", lost_cnt_o, 11);

        // Saturation
        repeat (8) step(3'b111, 1'b1);
        step(3'b000, 1'b1); @(negedge clk_i); check("sat", lost_cnt_o, MAX);
        step(3'b000, 1'b1); @(negedge clk_i); check("sat_hold", lost_cnt_o, MAX);

        // Reset in the response cycle
        step(3'b001, 1'b1); @(negedge clk_i); check("pre_rst_ack", rd_ack_o, 3'b001);
        @(posedge clk_i); #1 rst_ni = 1'b0; rd_req_i = '0;
        @(negedge clk_i); check("rst_mid_rvld", rd_rvld_o, 3'b000);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        step(3'b000, 1'b1); @(negedge clk_i);
        check("post_rst_rvld", rd_rvld_o, 3'b000);
        check("post_rst_lost", lost_cnt_o, 0);
        step(3'b011, 1'b1); @(negedge clk_i); check("post_rst_ptr", rd_ack_o, 3'b001);
        step(3'b000, 1'b1);
        @(negedge clk_i);
        @(posedge clk_i); #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
